// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential binary32 multiplier.
// Also provides the FSM state encoding used by fp_mul_seq_ctrl.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    SPECIAL,
    MULT,
    NORM,
    ROUND,
    DONE
  } fp_mul_state_e;

  function automatic logic [31:0] pack_fp(input logic s, input logic [7:0] e, input logic [22:0] f);
    return {s, e, f};
  endfunction

endpackage

// File: rtl/fp_shift_add_mult.sv
// Iterative 24x24 unsigned multiplier: consumes BITS_PER_CYCLE multiplier bits per step, LSB first.
// 'last' is high during the step that completes the product.
module fp_shift_add_mult #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] prod,
  output logic        last
);

  localparam int ITER = 24 / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  logic [47:0]   a_sh;
  logic [23:0]   b_sh;
  logic [CW-1:0] cnt;
  logic [47:0]   partial;

  // Multiplicand is pre-shifted each step, so the partial sum needs no position offset.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (b_sh[i]) partial = partial + (a_sh << i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      prod <= '0;
      cnt  <= '0;
    end else if (load) begin
      a_sh <= {24'b0, a};
      b_sh <= b;
      prod <= '0;
      cnt  <= '0;
    end else if (step) begin
      prod <= prod + partial;
      a_sh <= a_sh << BITS_PER_CYCLE;
      b_sh <= b_sh >> BITS_PER_CYCLE;
      cnt  <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(ITER - 1));

endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// Sequencing controller for binary32 multiply: unpack, iterative mantissa product,
// normalise, round-to-nearest-even and pack, with a short path for special operands.
module fp_mul_seq_ctrl
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  localparam logic signed [9:0] BIAS10 = 10'(BIAS);

  fp_mul_state_e state, next_state;

  fp32_t              op_a, op_b;
  logic               load, step, last;
  logic [47:0]        prod;
  logic               res_sign;
  logic signed [9:0]  exp_sum;
  logic signed [9:0]  exp_r;
  logic [22:0]        mant_r;
  logic               guard_r, sticky_r;

  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic               is_special;
  logic [31:0]        special_out;
  logic               special_invalid;

  logic               round_up;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  exp_rnd;
  logic [31:0]        round_out;
  logic               round_ov, round_uf;

  fp_shift_add_mult #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_mult (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    ({1'b1, op_a.frac}),
    .b    ({1'b1, op_b.frac}),
    .prod (prod),
    .last (last)
  );

  // Denormal inputs (exp==0) are treated as zero.
  assign a_zero = (op_a.exp == 8'h00);
  assign b_zero = (op_b.exp == 8'h00);
  assign a_inf  = (op_a.exp == EXP_MAX) && (op_a.frac == 23'h0);
  assign b_inf  = (op_b.exp == EXP_MAX) && (op_b.frac == 23'h0);
  assign a_nan  = (op_a.exp == EXP_MAX) && (op_a.frac != 23'h0);
  assign b_nan  = (op_b.exp == EXP_MAX) && (op_b.frac != 23'h0);
  assign is_special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;
  assign res_sign   = op_a.sign ^ op_b.sign;

  always_comb begin
    special_out     = pack_fp(res_sign, 8'h00, 23'h0);
    special_invalid = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      special_out     = QNAN;
      special_invalid = 1'b1;
    end else if (a_inf || b_inf) begin
      special_out = pack_fp(res_sign, EXP_MAX, 23'h0);
    end
  end

  assign exp_sum = $signed({2'b00, op_a.exp}) + $signed({2'b00, op_b.exp}) - BIAS10;

  // A mantissa carry leaves mant_rnd[22:0] at zero, so only the exponent needs bumping.
  always_comb begin
    round_up  = guard_r & (sticky_r | mant_r[0]);
    mant_rnd  = {1'b0, mant_r} + {23'b0, round_up};
    exp_rnd   = exp_r + (mant_rnd[23] ? 10'sd1 : 10'sd0);
    round_ov  = 1'b0;
    round_uf  = 1'b0;
    round_out = pack_fp(res_sign, exp_rnd[7:0], mant_rnd[22:0]);
    if (exp_rnd >= 10'sd255) begin
      round_out = pack_fp(res_sign, EXP_MAX, 23'h0);
      round_ov  = 1'b1;
    end else if (exp_rnd <= 10'sd0) begin
      round_out = pack_fp(res_sign, 8'h00, 23'h0);
      round_uf  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE:    if (start) next_state = UNPACK;
      UNPACK: begin
        if (is_special) begin
          next_state = SPECIAL;
        end else begin
          next_state = MULT;
          load       = 1'b1;
        end
      end
      MULT: begin
        step = 1'b1;
        if (last) next_state = NORM;
      end
      NORM:    next_state = ROUND;
      ROUND:   next_state = DONE;
      SPECIAL: next_state = IDLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      exp_r    <= '0;
      mant_r   <= '0;
      guard_r  <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        op_a <= fp32_t'(in1);
        op_b <= fp32_t'(in2);
      end
      if (state == NORM) begin
        if (prod[47]) begin
          mant_r   <= prod[46:24];
          guard_r  <= prod[23];
          sticky_r <= |prod[22:0];
          exp_r    <= exp_sum + 10'sd1;
        end else begin
          mant_r   <= prod[45:23];
          guard_r  <= prod[22];
          sticky_r <= |prod[21:0];
          exp_r    <= exp_sum;
        end
      end
    end
  end

  // Result and flags are registered on entry to the done cycle and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      done <= (next_state == SPECIAL) || (next_state == DONE);
      if (state == UNPACK && is_special) begin
        out       <= special_out;
        invalid   <= special_invalid;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else if (state == ROUND) begin
        out       <= round_out;
        overflow  <= round_ov;
        underflow <= round_uf;
        invalid   <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Scoreboard bench for fp_mul_seq_ctrl: directed and random operand pairs, held start,
// mid-operation reset, and a BITS_PER_CYCLE=4 latency check on a second instance.
module tb_fp_mul_seq_ctrl;

  typedef struct {
    logic [31:0] res;
    logic        ov;
    logic        uf;
    logic        inv;
    logic        spec;
    int          done_cyc;
    int          busy_len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        busy, done, overflow, underflow, invalid;
  logic [31:0] out;
  logic        busy4, done4, overflow4, underflow4, invalid4;
  logic [31:0] out4;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  exp_t sb_q[$];

  fp_mul_seq_ctrl #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  fp_mul_seq_ctrl #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in1(in1), .in2(in2),
    .busy(busy4), .done(done4), .out(out4),
    .overflow(overflow4), .underflow(underflow4), .invalid(invalid4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer product, then round-to-nearest-even on the discarded remainder.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic s;
    int ea, eb, e, sh;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned ma, mb, p, q, rem, half;
    r = '{res: 32'h0, ov: 1'b0, uf: 1'b0, inv: 1'b0, spec: 1'b1, done_cyc: 0, busy_len: 0};
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      r.res = 32'h7FC00000;
      r.inv = 1'b1;
      return r;
    end
    if (a_inf || b_inf) begin
      r.res = {s, 8'hFF, 23'h0};
      return r;
    end
    if (a_zero || b_zero) begin
      r.res = {s, 31'h0};
      return r;
    end
    r.spec = 1'b0;
    ma = 64'(a[22:0]) + (64'd1 << 23);
    mb = 64'(b[22:0]) + (64'd1 << 23);
    p  = ma * mb;
    e  = ea + eb - 127;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e = e + 1;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      r.res = {s, 8'hFF, 23'h0};
      r.ov  = 1'b1;
    end else if (e <= 0) begin
      r.res = {s, 31'h0};
      r.uf  = 1'b1;
    end else begin
      r.res = {s, e[7:0], q[22:0]};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_operand();
    int sel;
    logic [7:0] e;
    sel = int'($urandom_range(0, 9));
    if (sel < 7)       e = 8'($urandom_range(90, 164));
    else if (sel == 7) e = 8'($urandom_range(1, 254));
    else if (sel == 8) e = 8'h00;
    else               e = 8'hFF;
    return {1'($urandom_range(0, 1)), e, ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom)};
  endfunction

  task automatic waitIdle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_wait: busy=%0b done=%0b required 0/0 within 200 cycles", busy, done);
    end
  endtask

  task automatic pushExpect(input exp_t e, input int t);
    exp_t x;
    x = e;
    x.done_cyc = t + (x.spec ? 2 : 28);
    x.busy_len = x.spec ? 2 : 28;
    sb_q.push_back(x);
  endtask

  // use_ref=1 takes the expectation from the caller (directed constants), otherwise from the model.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit use_ref,
                               input logic [31:0] ref_out, input logic [2:0] ref_flags,
                               input bit expect_done);
    exp_t e;
    int t;
    waitIdle();
    e = model(a, b);
    if (use_ref) begin
      e.res = ref_out;
      {e.ov, e.uf, e.inv} = ref_flags;
    end
    in1   = a;
    in2   = b;
    start = 1'b1;
    t     = cyc;
    if (expect_done) pushExpect(e, t);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_done: done=1 at cycle %0d with no outstanding transaction", cyc);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (out !== e.res) begin
      errors++;
      $display("[TB] FAIL result: out=%08h required %08h", out, e.res);
    end
    checks++;
    if ({overflow, underflow, invalid} !== {e.ov, e.uf, e.inv}) begin
      errors++;
      $display("[TB] FAIL flags: ov/uf/inv=%b required %b", {overflow, underflow, invalid}, {e.ov, e.uf, e.inv});
    end
    checks++;
    if (cyc != e.done_cyc) begin
      errors++;
      $display("[TB] FAIL done_cycle: done at %0d required %0d", cyc, e.done_cyc);
    end
    checks++;
    if (busy_cnt != e.busy_len) begin
      errors++;
      $display("[TB] FAIL busy_len: busy for %0d cycles required %0d", busy_cnt, e.busy_len);
    end
  endtask

  // Monitor samples 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          checkOutput();
          busy_cnt = 0;
        end
      end
    end
  end

  logic [31:0] dir_a   [9] = '{32'h40000000, 32'h3FC00000, 32'h3F800001, 32'h3F800001, 32'h7F800000,
                               32'hFF800000, 32'h00000001, 32'h7F000000, 32'h00800000};
  logic [31:0] dir_b   [9] = '{32'h40400000, 32'h3FC00000, 32'h3F800001, 32'h3F7FFFFF, 32'h00000000,
                               32'h40000000, 32'h40000000, 32'h7F000000, 32'h00800000};
  logic [31:0] dir_out [9] = '{32'h40C00000, 32'h40100000, 32'h3F800002, 32'h3F800000, 32'h7FC00000,
                               32'hFF800000, 32'h00000000, 32'h7F800000, 32'h00000000};
  logic [2:0]  dir_flg [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b100, 3'b010};

  initial begin
    logic [31:0] ha, hb;
    exp_t        e;
    int          t, n;

    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, out, overflow, underflow, invalid} !== 36'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy/done/out/ov/uf/inv=%0b/%0b/%08h/%0b/%0b/%0b required all 0",
               busy, done, out, overflow, underflow, invalid);
    end
    rst = 1'b0;

    for (int i = 0; i < 9; i++) applyStimulus(dir_a[i], dir_b[i], 1'b1, dir_out[i], dir_flg[i], 1'b1);

    for (int i = 0; i < 40; i++) applyStimulus(rand_operand(), rand_operand(), 1'b0, 32'h0, 3'b0, 1'b1);

    // Start held high: every cycle the controller is idle is an accepted start.
    waitIdle();
    ha = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
    hb = {1'b1, 8'($urandom_range(100, 150)), 23'($urandom)};
    in1 = ha;
    in2 = hb;
    for (int i = 0; i < 100; i++) begin
      start = 1'b1;
      if (!busy) pushExpect(model(ha, hb), cyc);
      @(negedge clk);
    end
    start = 1'b0;

    // Abort mid-operation: no done may appear, and outputs return to zero.
    applyStimulus(32'h40000000, 32'h40400000, 1'b0, 32'h0, 3'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, out, overflow, underflow, invalid} !== 36'h0) begin
      errors++;
      $display("[TB] FAIL abort_state: busy/done/out/ov/uf/inv=%0b/%0b/%08h/%0b/%0b/%0b required all 0",
               busy, done, out, overflow, underflow, invalid);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    applyStimulus(32'h40000000, 32'h40400000, 1'b1, 32'h40C00000, 3'b000, 1'b1);
    applyStimulus(rand_operand(), rand_operand(), 1'b0, 32'h0, 3'b0, 1'b1);

    // Four bits per cycle: same product, done ten cycles after the start cycle.
    waitIdle();
    in1    = 32'h40000000;
    in2    = 32'h40400000;
    start4 = 1'b1;
    t      = cyc;
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (!done4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done4) begin
      errors++;
      $display("[TB] FAIL bpc4_done: no done within 50 cycles, required at cycle %0d", t + 10);
    end else begin
      e = model(32'h40000000, 32'h40400000);
      if (cyc != t + 10) begin
        errors++;
        $display("[TB] FAIL bpc4_latency: done at %0d required %0d", cyc, t + 10);
      end
      checks++;
      if (out4 !== 32'h40C00000 || {overflow4, underflow4, invalid4} !== {e.ov, e.uf, e.inv}) begin
        errors++;
        $display("[TB] FAIL bpc4_result: out=%08h flags=%b required 40C00000 flags=000",
                 out4, {overflow4, underflow4, invalid4});
      end
    end

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d transactions without done, required 0", sb_q.size());
    end
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
